// File: rtl/router_trace_buffer.sv
// rtl/router_trace_buffer.sv - circular trace capture with pre/post-trigger window and oldest-first readout
// Optional macro TRACE_TIMESTAMP_EN prepends a TSw-bit capture timestamp to every stored word.
module router_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int TRACEw    = 32,
    parameter int POST_TRIG = 8,
    parameter int TSw       = 16,
    localparam int Aw       = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_EN    = 1,
`else
    localparam int TS_EN    = 0,
`endif
    localparam int DW       = TRACEw + TS_EN * TSw
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic [TRACEw-1:0] trace_signal,
    input  logic              arm,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              rd_last,
    output logic [1:0]        state,
    output logic [Aw:0]       count,
    output logic [Aw:0]       trig_index
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [Aw-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [Aw:0]     count_q, count_d, post_cnt_q, post_cnt_d;
    logic [Aw:0]     remaining_q, remaining_d, trig_index_q, trig_index_d;
    logic            rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [DW-1:0]   rd_data_q;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   wr_word;
    logic            wr_en, rd_fire, done_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [TSw-1:0]  ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (arm)
            ts_d = '0;
        else if (wr_en)
            ts_d = ts_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end

    assign wr_word = {ts_q, trace_signal};
`else
    assign wr_word = trace_signal;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (arm)
            state_d = PRE;
        else begin
            case (state_q)
                PRE:     if (trigger) state_d = (POST_TRIG == 0) ? DONE : POST;
                POST:    if (post_cnt_q == (Aw+1)'(1)) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // arm outranks both capture and readout in the same cycle
    assign wr_en      = !arm && (state_q == PRE || state_q == POST);
    assign rd_fire    = !arm && (state_q == DONE) && rd_en && (remaining_q != '0);
    assign done_entry = (state_d == DONE) && (state_q != DONE);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        post_cnt_d   = post_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        remaining_d  = remaining_q;
        trig_index_d = trig_index_q;
        if (arm) begin
            wr_ptr_d     = '0;
            count_d      = '0;
            post_cnt_d   = '0;
            remaining_d  = '0;
            trig_index_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != (Aw+1)'(DEPTH))
                count_d = count_q + 1'b1;
            if (state_q == PRE && trigger)
                post_cnt_d = (Aw+1)'(POST_TRIG);
            else if (state_q == POST)
                post_cnt_d = post_cnt_q - 1'b1;
            // oldest entry sits count slots behind the write pointer
            if (done_entry) begin
                rd_ptr_d     = wr_ptr_d - count_d[Aw-1:0];
                remaining_d  = count_d;
                trig_index_d = count_d - (Aw+1)'(POST_TRIG + 1);
            end
        end
        if (rd_fire) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end
        rd_valid_d = rd_fire;
        rd_last_d  = rd_fire && (remaining_q == (Aw+1)'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            post_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            remaining_q  <= '0;
            trig_index_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            post_cnt_q   <= post_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            remaining_q  <= remaining_d;
            trig_index_q <= trig_index_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        rd_data_q <= '0;
        else if (rd_fire) rd_data_q <= mem[rd_ptr_q];
    end

    always_comb begin
        state      = state_q;
        count      = count_q;
        trig_index = trig_index_q;
        rd_valid   = rd_valid_q;
        rd_last    = rd_last_q;
        rd_data    = rd_data_q;
    end

endmodule

// File: doc/router_trace_buffer.md
# router_trace_buffer

Debug capture stage sitting directly downstream of the router's `trigger` / `trace_signal` outputs. It continuously records `trace_signal` into a circular on-chip buffer once armed, freezes a window of pre- and post-trigger samples when `trigger` fires, and then streams the frozen window out oldest-first through a simple read handshake. It gives post-silicon/FPGA visibility of one router's internal events without stalling the NoC.

## Interface
Parameters:
- `DEPTH`, 16: buffer entries; power of two, ≥ 4.
- `Aw`, log2(`DEPTH`): pointer width (localparam).
- `TRACEw`, 32: trace word width; matches router `trace_signal`.
- `POST_TRIG`, 8: samples kept after the trigger sample; 0 ≤ `POST_TRIG` ≤ `DEPTH`-1.
- `TSw`, 16: timestamp width; used only with `TRACE_TIMESTAMP_EN`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high.
- `trigger`  in  1  from router; level, sampled each cycle.
- `trace_signal`  in  `TRACEw`  from router; sampled each cycle.
- `arm`  in  1  one-cycle pulse: clear and start capture.
- `rd_en`  in  1  request next stored word.
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `rd_data`  out  `DW`  stored word; `DW`=`TRACEw`, or `TSw`+`TRACEw` with the macro.
- `rd_last`  out  1  with `rd_valid`: final word of the window.
- `state`  out  2  0 IDLE, 1 PRE, 2 POST, 3 DONE.
- `count`  out  `Aw`+1  valid entries held (saturates at `DEPTH`).
- `trig_index`  out  `Aw`+1  readout index of the trigger sample; valid in DONE.

## Operation
- IDLE: nothing written. `arm` → PRE.
- PRE: every cycle writes `trace_signal` at `wr_ptr`; `wr_ptr`++ (wraps mod `DEPTH`); `count`++ saturating at `DEPTH`. If `trigger`=1, that cycle's sample is written as the trigger sample. Then → DONE if `POST_TRIG`=0, else → POST with `post_cnt`=`POST_TRIG`.
- POST: writes continue; `post_cnt`-- per write; the write with `post_cnt`=1 → DONE. `trigger` is ignored.
- DONE: no writes; buffer frozen. `trig_index` = `count`-1-`POST_TRIG`. `rd_ptr` is initialised to `wr_ptr`-`count` (oldest entry) on entry.
- Readout (DONE only): `rd_en` with `remaining`>0 → next cycle `rd_valid`=1, `rd_data`=mem[`rd_ptr`], `rd_ptr`++, `remaining`--. `rd_last`=1 when that word was the final one. `rd_en` with `remaining`=0, or outside DONE, is ignored (`rd_valid`=0).
- `arm` in any state: `wr_ptr`, `count`, `post_cnt` and `remaining` clear; → PRE. `arm` has priority over a same-cycle `trigger`; that cycle writes nothing.
- The block stays in DONE after readout until `arm`.

## Timing
- Reset values: `state`=IDLE, `count`=0, `trig_index`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0; all pointers and counters 0. Memory contents are not cleared.
- Capture has zero added latency: the sample in cycle N is written at the cycle-N edge.
- Read latency is 1 cycle from `rd_en` to `rd_valid`/`rd_data`. Back-to-back `rd_en` gives one word per cycle.
- `reset` mid-operation (PRE, POST, or during readout) forces IDLE immediately and asynchronously. `trigger` is ignored until the next `arm`.
- Memory is a synchronous-write, registered-read array, inferable as block RAM.

## Configuration
- Macro: `TRACE_TIMESTAMP_EN`.
- Defined:
  - A `TSw`-bit counter clears on `arm`, increments every cycle in PRE and POST, and wraps.
  - Each write stores {timestamp, `trace_signal`}, giving `rd_data` width `TSw`+`TRACEw`.
  - The first sample after `arm` carries timestamp 0.
- Undefined: no counter; `rd_data` is `TRACEw` bits.

## Test plan
`DEPTH`=16, `POST_TRIG`=4, `trace_signal` = sample number counted from 0 at the first cycle after `arm`.
- Long pre-trigger: `trigger` on sample 20 → DONE after sample 24; `count`=16; `trig_index`=11; 16 reads return 9..24; `rd_last` only with 24.
- Early trigger: `trigger` on sample 3 → DONE after sample 7; `count`=8; `trig_index`=3; reads return 0..7; 9th `rd_en` gives no `rd_valid`.
- `arm` in the same cycle as `trigger` → `state`=PRE, `count`=0 next cycle; a later `trigger` on sample 5 is honoured normally.
- `reset` during POST → all outputs read their reset values next edge. `trigger` pulses then give `state`=IDLE and `count`=0 until `arm`.
- Protocol: `rd_en` during PRE → no `rd_valid`. In DONE, `rd_en` held for 16 cycles → 16 consecutive valid words, then `rd_valid`=0. Re-`arm` → PRE with `count`=0.
- With `TRACE_TIMESTAMP_EN`: scenario 1 → the upper `TSw` bits equal the lower `TRACEw` bits (9..24) for every word read.
